// File: rtl/rs_alu_scheduler_pkg.sv
// Shared widths, broadcast/payload types and operand-capture helpers for the
// ALU reservation station.
package rs_alu_scheduler_pkg;

    localparam int DATA_LEN        = 32;
    localparam int ADDR_LEN        = 32;
    localparam int RRF_SEL         = 6;
    localparam int ALU_OP_WIDTH    = 4;
    localparam int SRC_A_SEL_WIDTH = 2;
    localparam int SRC_B_SEL_WIDTH = 2;
    localparam int CTL_W           = ALU_OP_WIDTH + SRC_A_SEL_WIDTH + SRC_B_SEL_WIDTH;
    localparam int RS_ALU_ENT_NUM  = 4;
    localparam int RS_ALU_ENT_SEL  = 2;

    typedef struct packed {
        logic                we;
        logic [RRF_SEL-1:0]  tag;
        logic [DATA_LEN-1:0] data;
    } wb_t;

    typedef struct packed {
        logic [DATA_LEN-1:0] imm;
        logic [ADDR_LEN-1:0] pc;
        logic [CTL_W-1:0]    ctl;
        logic [RRF_SEL-1:0]  rrftag;
    } rs_payload_t;

    function automatic logic tag_hit(input logic we, input logic [RRF_SEL-1:0] wb_tag,
                                     input logic [RRF_SEL-1:0] src_tag);
        return we && (wb_tag == src_tag);
    endfunction

    // Returns {ready, value}; b[0] has the highest priority, b[3] the lowest.
    function automatic logic [DATA_LEN:0] bypass(input logic rdy, input logic [DATA_LEN-1:0] src,
                                                 input wb_t [3:0] b);
        logic [DATA_LEN:0] res;
        res = {rdy, src};
        for (int k = 3; k >= 0; k--) begin
            if (!rdy && tag_hit(b[k].we, b[k].tag, src[RRF_SEL-1:0])) begin
                res = {1'b1, b[k].data};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_alu_scheduler_entry.sv
// One reservation-station slot: busy/ready state, operand wakeup compare and
// data capture from the live writeback broadcasts.
module rs_alu_scheduler_entry
    import rs_alu_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                we,
    input  logic [DATA_LEN-1:0] wr_src1,
    input  logic                wr_rdy1,
    input  logic [DATA_LEN-1:0] wr_src2,
    input  logic                wr_rdy2,
    input  rs_payload_t         wr_payload,
    input  logic                clear,
    input  wb_t                 wb1,
    input  wb_t                 wb2,
    output logic                busy,
    output logic                ready,
    output logic [DATA_LEN-1:0] src1,
    output logic [DATA_LEN-1:0] src2,
    output rs_payload_t         payload
);

    logic                busy_reg;
    logic                rdy1_reg;
    logic                rdy2_reg;
    logic [DATA_LEN-1:0] src1_reg;
    logic [DATA_LEN-1:0] src2_reg;
    rs_payload_t         payload_reg;

    logic hit1_a, hit1_b, hit2_a, hit2_b;

    assign hit1_a = busy_reg & ~rdy1_reg & tag_hit(wb1.we, wb1.tag, src1_reg[RRF_SEL-1:0]);
    assign hit1_b = busy_reg & ~rdy1_reg & tag_hit(wb2.we, wb2.tag, src1_reg[RRF_SEL-1:0]);
    assign hit2_a = busy_reg & ~rdy2_reg & tag_hit(wb1.we, wb1.tag, src2_reg[RRF_SEL-1:0]);
    assign hit2_b = busy_reg & ~rdy2_reg & tag_hit(wb2.we, wb2.tag, src2_reg[RRF_SEL-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= 1'b0;
            rdy1_reg <= 1'b0;
            rdy2_reg <= 1'b0;
        end else if (flush) begin
            busy_reg <= 1'b0;
        end else if (we) begin
            busy_reg <= 1'b1;
            rdy1_reg <= wr_rdy1;
            rdy2_reg <= wr_rdy2;
        end else begin
            if (clear) begin
                busy_reg <= 1'b0;
            end
            if (hit1_a | hit1_b) begin
                rdy1_reg <= 1'b1;
            end
            if (hit2_a | hit2_b) begin
                rdy2_reg <= 1'b1;
            end
        end
    end

    // Operand payload carries no reset: it is only observed while busy and ready.
    always_ff @(posedge clk) begin
        if (we) begin
            src1_reg    <= wr_src1;
            src2_reg    <= wr_src2;
            payload_reg <= wr_payload;
        end else begin
            if (hit1_a) begin
                src1_reg <= wb1.data;
            end else if (hit1_b) begin
                src1_reg <= wb2.data;
            end
            if (hit2_a) begin
                src2_reg <= wb1.data;
            end else if (hit2_b) begin
                src2_reg <= wb2.data;
            end
        end
    end

    assign busy    = busy_reg;
    assign ready   = busy_reg & rdy1_reg & rdy2_reg;
    assign src1    = src1_reg;
    assign src2    = src2_reg;
    assign payload = payload_reg;

endmodule

// File: rtl/rs_alu_scheduler.sv
// ALU reservation station: dispatch with writeback bypass, per-entry wakeup,
// lowest-index issue select held stable while the ALU stalls.
module rs_alu_scheduler
    import rs_alu_scheduler_pkg::*;
#(
    parameter int ENT_NUM = RS_ALU_ENT_NUM,
    parameter int ENT_SEL = RS_ALU_ENT_SEL
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                dp_we,
    input  logic [DATA_LEN-1:0] dp_src1,
    input  logic                dp_rdy1,
    input  logic [DATA_LEN-1:0] dp_src2,
    input  logic                dp_rdy2,
    input  logic [DATA_LEN-1:0] dp_imm,
    input  logic [ADDR_LEN-1:0] dp_pc,
    input  logic [CTL_W-1:0]    dp_ctl,
    input  logic [RRF_SEL-1:0]  dp_rrftag,
    output logic                full,
    input  logic                wb_we1,
    input  logic [RRF_SEL-1:0]  wb_tag1,
    input  logic [DATA_LEN-1:0] wb_data1,
    input  logic                wb_we2,
    input  logic [RRF_SEL-1:0]  wb_tag2,
    input  logic [DATA_LEN-1:0] wb_data2,
    input  logic                iss_ack,
    output logic                iss_valid,
    output logic [DATA_LEN-1:0] iss_src1,
    output logic [DATA_LEN-1:0] iss_src2,
    output logic [DATA_LEN-1:0] iss_imm,
    output logic [ADDR_LEN-1:0] iss_pc,
    output logic [CTL_W-1:0]    iss_ctl,
    output logic [RRF_SEL-1:0]  iss_rrftag
);

    wb_t         wb1_now, wb2_now;
    wb_t         wb1_dly_reg, wb2_dly_reg;
    wb_t [3:0]   bcast;
    rs_payload_t wr_payload;

    logic [DATA_LEN:0] byp1, byp2;

    logic [ENT_NUM-1:0]  ent_busy;
    logic [ENT_NUM-1:0]  ent_ready;
    logic [DATA_LEN-1:0] ent_src1 [ENT_NUM];
    logic [DATA_LEN-1:0] ent_src2 [ENT_NUM];
    rs_payload_t         ent_payload [ENT_NUM];

    logic [ENT_SEL-1:0] free_idx;
    logic [ENT_SEL-1:0] ready_idx;
    logic [ENT_SEL-1:0] sel_idx;
    logic [ENT_SEL-1:0] lock_idx_reg;
    logic               lock_reg;
    logic               dp_write;
    logic               issue_fire;
    rs_payload_t        sel_payload;

    assign wb1_now    = '{we: wb_we1, tag: wb_tag1, data: wb_data1};
    assign wb2_now    = '{we: wb_we2, tag: wb_tag2, data: wb_data2};
    assign bcast      = {wb2_dly_reg, wb1_dly_reg, wb2_now, wb1_now};
    assign wr_payload = '{imm: dp_imm, pc: dp_pc, ctl: dp_ctl, rrftag: dp_rrftag};
    assign byp1       = bypass(dp_rdy1, dp_src1, bcast);
    assign byp2       = bypass(dp_rdy2, dp_src2, bcast);

    // Delayed copies cover a producer that broadcast one cycle before dispatch.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb1_dly_reg.we <= 1'b0;
            wb2_dly_reg.we <= 1'b0;
        end else begin
            wb1_dly_reg <= wb1_now;
            wb2_dly_reg <= wb2_now;
        end
    end

    always_comb begin
        free_idx  = '0;
        ready_idx = '0;
        for (int i = ENT_NUM - 1; i >= 0; i--) begin
            if (!ent_busy[i]) begin
                free_idx = ENT_SEL'(i);
            end
            if (ent_ready[i]) begin
                ready_idx = ENT_SEL'(i);
            end
        end
    end

    assign full       = &ent_busy;
    assign iss_valid  = |ent_ready;
    assign sel_idx    = lock_reg ? lock_idx_reg : ready_idx;
    assign dp_write   = dp_we & ~full & ~flush & ~reset;
    assign issue_fire = iss_valid & iss_ack & ~flush;

    // An offered but unaccepted op stays selected even if a lower entry wakes up.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            lock_reg <= 1'b0;
        end else begin
            lock_reg     <= iss_valid & ~iss_ack;
            lock_idx_reg <= sel_idx;
        end
    end

    for (genvar gi = 0; gi < ENT_NUM; gi++) begin : g_ent
        rs_alu_scheduler_entry u_entry (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .we         (dp_write && (free_idx == ENT_SEL'(gi))),
            .wr_src1    (byp1[DATA_LEN-1:0]),
            .wr_rdy1    (byp1[DATA_LEN]),
            .wr_src2    (byp2[DATA_LEN-1:0]),
            .wr_rdy2    (byp2[DATA_LEN]),
            .wr_payload (wr_payload),
            .clear      (issue_fire && (sel_idx == ENT_SEL'(gi))),
            .wb1        (wb1_now),
            .wb2        (wb2_now),
            .busy       (ent_busy[gi]),
            .ready      (ent_ready[gi]),
            .src1       (ent_src1[gi]),
            .src2       (ent_src2[gi]),
            .payload    (ent_payload[gi])
        );
    end

    assign sel_payload = ent_payload[sel_idx];
    assign iss_src1    = ent_src1[sel_idx];
    assign iss_src2    = ent_src2[sel_idx];
    assign iss_imm     = sel_payload.imm;
    assign iss_pc      = sel_payload.pc;
    assign iss_ctl     = sel_payload.ctl;
    assign iss_rrftag  = sel_payload.rrftag;

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Scoreboard bench: a slot-list model predicts each cycle's outputs into a queue
// that a negedge monitor compares against the scheduler.
module tb_rs_alu_scheduler;
    import rs_alu_scheduler_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset, flush, dp_we, dp_rdy1, dp_rdy2, full;
    logic [DATA_LEN-1:0] dp_src1, dp_src2, dp_imm;
    logic [ADDR_LEN-1:0] dp_pc;
    logic [CTL_W-1:0]    dp_ctl;
    logic [RRF_SEL-1:0]  dp_rrftag, wb_tag1, wb_tag2, iss_rrftag;
    logic                wb_we1, wb_we2, iss_ack, iss_valid;
    logic [DATA_LEN-1:0] wb_data1, wb_data2, iss_src1, iss_src2, iss_imm;
    logic [ADDR_LEN-1:0] iss_pc;
    logic [CTL_W-1:0]    iss_ctl;

    rs_alu_scheduler dut (
        .clk(clk), .reset(reset), .flush(flush), .dp_we(dp_we),
        .dp_src1(dp_src1), .dp_rdy1(dp_rdy1), .dp_src2(dp_src2), .dp_rdy2(dp_rdy2),
        .dp_imm(dp_imm), .dp_pc(dp_pc), .dp_ctl(dp_ctl), .dp_rrftag(dp_rrftag),
        .full(full), .wb_we1(wb_we1), .wb_tag1(wb_tag1), .wb_data1(wb_data1),
        .wb_we2(wb_we2), .wb_tag2(wb_tag2), .wb_data2(wb_data2), .iss_ack(iss_ack),
        .iss_valid(iss_valid), .iss_src1(iss_src1), .iss_src2(iss_src2),
        .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_ctl(iss_ctl), .iss_rrftag(iss_rrftag)
    );

    typedef struct {
        bit                  full;
        bit                  valid;
        logic [DATA_LEN-1:0] s1, s2, imm;
        logic [ADDR_LEN-1:0] pc;
        logic [CTL_W-1:0]    ctl;
        logic [RRF_SEL-1:0]  tag;
    } exp_t;

    typedef struct {
        bit                  busy, r1, r2;
        logic [DATA_LEN-1:0] v1, v2, imm;
        logic [ADDR_LEN-1:0] pc;
        logic [CTL_W-1:0]    ctl;
        logic [RRF_SEL-1:0]  tag;
    } slot_t;

    exp_t  exp_q[$];
    slot_t m[4];
    int    m_offer;
    bit    p_we1, p_we2;
    logic [RRF_SEL-1:0]  p_tag1, p_tag2;
    logic [DATA_LEN-1:0] p_d1, p_d2;
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int m_pick();
        if (m_offer >= 0) return m_offer;
        for (int i = 0; i < 4; i++)
            if (m[i].busy && m[i].r1 && m[i].r2) return i;
        return -1;
    endfunction

    task automatic m_resolve(input bit rdy, input logic [DATA_LEN-1:0] src,
                             output bit r, output logic [DATA_LEN-1:0] v);
        logic [RRF_SEL-1:0] t;
        t = src[RRF_SEL-1:0];
        r = 1'b1;
        v = src;
        if (!rdy) begin
            if (wb_we1 && wb_tag1 == t)      v = wb_data1;
            else if (wb_we2 && wb_tag2 == t) v = wb_data2;
            else if (p_we1 && p_tag1 == t)   v = p_d1;
            else if (p_we2 && p_tag2 == t)   v = p_d2;
            else                             r = 1'b0;
        end
    endtask

    task automatic m_step();
        int pick, freei;
        bit all_busy;
        if (reset) begin
            for (int i = 0; i < 4; i++) m[i].busy = 1'b0;
            m_offer = -1;
            p_we1 = 1'b0;
            p_we2 = 1'b0;
            return;
        end
        pick = m_pick();
        all_busy = 1'b1;
        freei = -1;
        for (int i = 0; i < 4; i++) begin
            if (!m[i].busy) begin
                all_busy = 1'b0;
                if (freei < 0) freei = i;
            end
        end
        if (flush) begin
            for (int i = 0; i < 4; i++) m[i].busy = 1'b0;
            m_offer = -1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m[i].busy && !m[i].r1) begin
                    if (wb_we1 && wb_tag1 == m[i].v1[RRF_SEL-1:0]) begin m[i].v1 = wb_data1; m[i].r1 = 1'b1; end
                    else if (wb_we2 && wb_tag2 == m[i].v1[RRF_SEL-1:0]) begin m[i].v1 = wb_data2; m[i].r1 = 1'b1; end
                end
                if (m[i].busy && !m[i].r2) begin
                    if (wb_we1 && wb_tag1 == m[i].v2[RRF_SEL-1:0]) begin m[i].v2 = wb_data1; m[i].r2 = 1'b1; end
                    else if (wb_we2 && wb_tag2 == m[i].v2[RRF_SEL-1:0]) begin m[i].v2 = wb_data2; m[i].r2 = 1'b1; end
                end
            end
            if (pick >= 0 && iss_ack) begin
                m[pick].busy = 1'b0;
                m_offer = -1;
            end else begin
                m_offer = pick;
            end
            if (dp_we && !all_busy) begin
                m_resolve(dp_rdy1, dp_src1, m[freei].r1, m[freei].v1);
                m_resolve(dp_rdy2, dp_src2, m[freei].r2, m[freei].v2);
                m[freei].imm  = dp_imm;
                m[freei].pc   = dp_pc;
                m[freei].ctl  = dp_ctl;
                m[freei].tag  = dp_rrftag;
                m[freei].busy = 1'b1;
            end
        end
        p_we1 = wb_we1; p_tag1 = wb_tag1; p_d1 = wb_data1;
        p_we2 = wb_we2; p_tag2 = wb_tag2; p_d2 = wb_data2;
    endtask

    // Called at posedge+1 with this cycle's inputs applied; returns at the next posedge+1.
    task automatic cycle();
        exp_t e;
        int   p;
        p = m_pick();
        e = '{default: '0};
        e.full = m[0].busy && m[1].busy && m[2].busy && m[3].busy;
        e.valid = (p >= 0);
        if (p >= 0) begin
            e.s1 = m[p].v1; e.s2 = m[p].v2; e.imm = m[p].imm;
            e.pc = m[p].pc; e.ctl = m[p].ctl; e.tag = m[p].tag;
        end
        exp_q.push_back(e);
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; flush = 0; dp_we = 0; dp_rdy1 = 0; dp_rdy2 = 0;
        dp_src1 = '0; dp_src2 = '0; dp_imm = '0; dp_pc = '0; dp_ctl = '0; dp_rrftag = '0;
        wb_we1 = 0; wb_tag1 = '0; wb_data1 = '0; wb_we2 = 0; wb_tag2 = '0; wb_data2 = '0;
        iss_ack = 0;
    endtask

    task automatic dispatch(input bit r1, input logic [DATA_LEN-1:0] s1, input bit r2,
                            input logic [DATA_LEN-1:0] s2, input logic [RRF_SEL-1:0] tag);
        dp_we = 1; dp_rdy1 = r1; dp_src1 = s1; dp_rdy2 = r2; dp_src2 = s2; dp_rrftag = tag;
        dp_imm = 32'h100 + 32'(tag); dp_pc = 32'h4000 + 32'(tag) * 4; dp_ctl = CTL_W'(tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("full", 64'(full), 64'(e.full));
                check("iss_valid", 64'(iss_valid), 64'(e.valid));
                if (e.valid) begin
                    check("iss_src1", 64'(iss_src1), 64'(e.s1));
                    check("iss_src2", 64'(iss_src2), 64'(e.s2));
                    check("iss_imm", 64'(iss_imm), 64'(e.imm));
                    check("iss_pc", 64'(iss_pc), 64'(e.pc));
                    check("iss_ctl", 64'(iss_ctl), 64'(e.ctl));
                    check("iss_rrftag", 64'(iss_rrftag), 64'(e.tag));
                    if (iss_ack)
                        $display("issue tag=%0d src1=%h src2=%h t=%0t", e.tag, e.s1, e.s2, $time);
                end
            end
        end
    end

    initial begin : driver
        idle_inputs();
        reset = 1;
        for (int i = 0; i < 4; i++) m[i] = '{default: '0};
        m_offer = -1; p_we1 = 0; p_we2 = 0;
        @(posedge clk);
        #1;
        cycle();
        reset = 0;
        check("reset_full", 64'(full), 64'(0));
        check("reset_valid", 64'(iss_valid), 64'(0));

        // Ready dispatch, then ack.
        dispatch(1, 32'd5, 1, 32'd7, 6'd3);
        cycle();
        idle_inputs();
        check("t1_valid", 64'(iss_valid), 64'(1));
        check("t1_src1", 64'(iss_src1), 64'(5));
        check("t1_src2", 64'(iss_src2), 64'(7));
        check("t1_tag", 64'(iss_rrftag), 64'(3));
        iss_ack = 1;
        cycle();
        iss_ack = 0;
        check("t1_drain", 64'(iss_valid), 64'(0));

        // Wakeup via wb port 2.
        dispatch(0, 32'd9, 1, 32'h22, 6'd10);
        cycle();
        idle_inputs();
        cycle();
        cycle();
        check("t2_wait", 64'(iss_valid), 64'(0));
        wb_we2 = 1; wb_tag2 = 6'd9; wb_data2 = 32'hDEAD;
        cycle();
        idle_inputs();
        check("t2_valid", 64'(iss_valid), 64'(1));
        check("t2_src1", 64'(iss_src1), 64'(32'hDEAD));
        iss_ack = 1;
        cycle();
        idle_inputs();

        // Bypass from the delayed copy of wb port 1.
        wb_we1 = 1; wb_tag1 = 6'd12; wb_data1 = 32'h55;
        cycle();
        idle_inputs();
        dispatch(1, 32'h11, 0, 32'd12, 6'd11);
        cycle();
        idle_inputs();
        check("t3_valid", 64'(iss_valid), 64'(1));
        check("t3_src2", 64'(iss_src2), 64'(32'h55));
        iss_ack = 1;
        cycle();
        idle_inputs();

        // Fill, drop a fifth dispatch, drain in order.
        for (int i = 0; i < 5; i++) begin
            dispatch(1, 32'(i * 10 + 1), 1, 32'(i), 6'(20 + i));
            cycle();
        end
        idle_inputs();
        check("t4_full", 64'(full), 64'(1));
        for (int i = 0; i < 4; i++) begin
            check("t4_order", 64'(iss_rrftag), 64'(20 + i));
            iss_ack = 1;
            cycle();
            if (i == 0) check("t4_full_drop", 64'(full), 64'(0));
        end
        idle_inputs();
        check("t4_empty", 64'(iss_valid), 64'(0));

        // Flush with a simultaneous dispatch.
        for (int i = 0; i < 3; i++) begin
            dispatch(1, 32'(i), 1, 32'(i), 6'(30 + i));
            cycle();
        end
        flush = 1;
        dispatch(1, 32'h77, 1, 32'h77, 6'd40);
        cycle();
        idle_inputs();
        check("t5_full", 64'(full), 64'(0));
        check("t5_valid", 64'(iss_valid), 64'(0));
        cycle();
        check("t5_nodisp", 64'(iss_valid), 64'(0));

        // Reset mid-operation, then the awaited tag arrives.
        dispatch(1, 32'h1, 1, 32'h2, 6'd41);
        cycle();
        dispatch(0, 32'd4, 1, 32'h3, 6'd42);
        cycle();
        idle_inputs();
        reset = 1;
        cycle();
        reset = 0;
        wb_we1 = 1; wb_tag1 = 6'd4; wb_data1 = 32'h44;
        cycle();
        idle_inputs();
        cycle();
        check("t6_valid", 64'(iss_valid), 64'(0));

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            dp_we     = 1'($urandom_range(0, 1));
            dp_rdy1   = 1'($urandom_range(0, 1));
            dp_rdy2   = 1'($urandom_range(0, 1));
            dp_src1   = dp_rdy1 ? $urandom : (($urandom & ~32'h3F) | $urandom_range(0, 15));
            dp_src2   = dp_rdy2 ? $urandom : (($urandom & ~32'h3F) | $urandom_range(0, 15));
            dp_imm    = $urandom;
            dp_pc     = $urandom;
            dp_ctl    = CTL_W'($urandom);
            dp_rrftag = RRF_SEL'($urandom);
            wb_we1    = ($urandom_range(0, 2) != 0);
            wb_tag1   = RRF_SEL'($urandom_range(0, 15));
            wb_data1  = $urandom;
            wb_we2    = ($urandom_range(0, 2) != 0);
            wb_tag2   = RRF_SEL'($urandom_range(0, 15));
            wb_data2  = $urandom;
            iss_ack   = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            cycle();
        end
        idle_inputs();
        cycle();
        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
